// File: rtl/sort_pkg.sv
// Shared definitions for the sort_ctrl block: FSM encodings and default geometry.
// Imported by the controller and the compare-and-swap unit.
package sort_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

endpackage : sort_pkg

// File: rtl/cmp_swap.sv
// Combinational compare-and-swap: orders two unsigned values and flags whether they were out of order.
// Equal inputs are reported as in order, which keeps the bubble sort stable.
module cmp_swap #(
  parameter int WIDTH = sort_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swap
);

  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule : cmp_swap

// File: rtl/sort_ctrl.sv
// Block sorter: loads DEPTH bytes, bubble-sorts them with one shared comparator, then streams them out.
// Passes terminate early as soon as a full pass makes no swap.
module sort_ctrl
  import sort_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW-1:0] PASS_MAX = IW'(DEPTH - 2);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [IW-1:0]    r_wr_idx;
  logic [IW-1:0]    r_rd_idx;
  logic [IW-1:0]    r_j;
  logic [IW-1:0]    r_pass;
  logic             r_swapped;

  logic [IW-1:0]    w_j_nxt;
  logic [IW-1:0]    w_pass_limit;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic             w_swap;
  logic             w_pass_end;
  logic             w_sort_done;
  logic             w_load_fire;
  logic             w_drain_fire;
  logic             w_last_out;

  assign w_j_nxt      = r_j + IW'(1);
  assign w_pass_limit = PASS_MAX - r_pass;
  assign w_pass_end   = (r_j == w_pass_limit);
  // The swap decided this cycle counts toward the pass, so fold it in before testing for "no swaps".
  assign w_sort_done  = w_pass_end && (!(r_swapped || w_swap) || (r_pass == PASS_MAX));

  assign w_load_fire  = (r_state == ST_LOAD) && in_valid;
  assign w_drain_fire = (r_state == ST_DRAIN) && out_ready;
  assign w_last_out   = (r_state == ST_DRAIN) && (r_rd_idx == LAST_IDX);

  cmp_swap #(.WIDTH(WIDTH)) u_cmp (
    .a    (r_buf[r_j]),
    .b    (r_buf[w_j_nxt]),
    .lo   (w_lo),
    .hi   (w_hi),
    .swap (w_swap)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOAD:  if (w_load_fire && (r_wr_idx == LAST_IDX)) w_state_next = ST_SORT;
      ST_SORT:  if (w_sort_done) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_drain_fire && w_last_out) w_state_next = ST_LOAD;
      default:  w_state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_j       <= '0;
      r_pass    <= '0;
      r_swapped <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_load_fire) begin
            r_wr_idx <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + IW'(1);
            if (r_wr_idx == LAST_IDX) begin
              r_pass    <= '0;
              r_j       <= '0;
              r_swapped <= 1'b0;
            end
          end
        end
        ST_SORT: begin
          if (!w_pass_end) begin
            r_j       <= w_j_nxt;
            r_swapped <= r_swapped | w_swap;
          end else if (w_sort_done) begin
            r_rd_idx <= '0;
          end else begin
            r_pass    <= r_pass + IW'(1);
            r_j       <= '0;
            r_swapped <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_drain_fire) begin
            r_rd_idx <= w_last_out ? '0 : r_rd_idx + IW'(1);
            if (w_last_out) r_wr_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Register array rather than RAM: a sort step reads and writes two entries in the same cycle.
  always_ff @(posedge clk) begin
    if (w_load_fire) begin
      r_buf[r_wr_idx] <= in_data;
    end else if ((r_state == ST_SORT) && w_swap) begin
      r_buf[r_j]     <= w_lo;
      r_buf[w_j_nxt] <= w_hi;
    end
  end

  assign in_ready  = (r_state == ST_LOAD);
  assign out_valid = (r_state == ST_DRAIN);
  assign out_last  = w_last_out;
  assign busy      = (r_state == ST_SORT);
  assign out_data  = r_buf[r_rd_idx];

endmodule : sort_ctrl

// File: tb/tb_sort_ctrl.sv
// Directed bench for sort_ctrl: table of blocks with hand-sorted results, plus stall, reset and
// spurious-input sequences. Inputs are driven and outputs sampled on the falling edge.
module tb_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] din  [8];
    logic [7:0] dout [8];
    int         busy_cycles;   // -1: not checked
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] cur_in  [8];
  logic [7:0] cur_exp [8];

  sort_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_block(input bit hold);
    for (int i = 0; i < 8; i++) begin
      in_data  = cur_in[i];
      in_valid = 1'b1;
      check("load_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
    end
    in_valid = hold;
    in_data  = hold ? 8'hEE : 8'h00;
  endtask

  task automatic count_busy(input int exp_cycles);
    int c;
    c = 0;
    while (busy === 1'b1 && c < 200) begin
      c++;
      @(negedge clk);
    end
    if (c >= 200) check("sort_timeout", 32'(c), 32'd0);
    if (exp_cycles >= 0) check("busy_cycles", 32'(c), 32'(exp_cycles));
    $display("block sorted in %0d cycles", c);
  endtask

  task automatic drain_full();
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", {31'd0, out_valid}, 32'd1);
      check("drain_data", {24'd0, out_data}, {24'd0, cur_exp[i]});
      check("drain_last", {31'd0, out_last}, (i == 7) ? 32'd1 : 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_drain_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_drain_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic drain_stalled();
    int n;
    for (int i = 0; i < 8; i++) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data", {24'd0, out_data}, {24'd0, cur_exp[i]});
      check("stall_last", {31'd0, out_last}, (i == 7) ? 32'd1 : 32'd0);
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        check("stall_hold_data", {24'd0, out_data}, {24'd0, cur_exp[i]});
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("post_stall_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_stall_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0].din  = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6};
    vecs[0].dout = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd9};
    vecs[0].busy_cycles = -1;
    vecs[1].din  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    vecs[1].dout = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    vecs[1].busy_cycles = 7;
    vecs[2].din  = '{8'd255, 8'd254, 8'd253, 8'd252, 8'd251, 8'd250, 8'd249, 8'd248};
    vecs[2].dout = '{8'd248, 8'd249, 8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255};
    vecs[2].busy_cycles = 28;
    vecs[3].din  = '{8'd128, 8'd5, 8'd200, 8'd5, 8'd0, 8'd127, 8'd255, 8'd0};
    vecs[3].dout = '{8'd0, 8'd0, 8'd5, 8'd5, 8'd127, 8'd128, 8'd200, 8'd255};
    vecs[3].busy_cycles = -1;

    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_last", {31'd0, out_last}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      cur_in  = vecs[v].din;
      cur_exp = vecs[v].dout;
      load_block(1'b0);
      check("busy_after_load", {31'd0, busy}, 32'd1);
      count_busy(vecs[v].busy_cycles);
      drain_full();
      $display("vector %0d drained", v);
    end

    // Random backpressure on a uniform block.
    for (int i = 0; i < 8; i++) begin
      cur_in[i]  = 8'hAA;
      cur_exp[i] = 8'hAA;
    end
    load_block(1'b0);
    count_busy(7);
    drain_stalled();
    $display("stalled drain of 0xAA block done");

    // Abort mid-sort, then a fresh block must sort cleanly.
    cur_in = vecs[2].din;
    load_block(1'b0);
    repeat (3) @(negedge clk);
    check("midsort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    cur_in  = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    cur_exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    load_block(1'b0);
    count_busy(28);
    drain_full();
    $display("post-abort block drained");

    // in_valid held high through SORT and DRAIN must be ignored.
    cur_in = vecs[0].din;
    cur_exp = vecs[0].dout;
    load_block(1'b1);
    count_busy(-1);
    drain_full();
    $display("spurious-input block drained");

    // A following block must still load from index 0.
    cur_in  = vecs[1].din;
    cur_exp = vecs[1].dout;
    load_block(1'b0);
    count_busy(7);
    drain_full();
    $display("follow-up block drained");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sort_ctrl

// File: doc/sort_ctrl.md
# sort_ctrl

Sequencing controller that buffers DEPTH unsigned bytes, sorts them ascending with a single shared compare-and-swap unit, and streams the result out. It sits between a byte producer and a byte consumer in the hello_world datapath. All ordering decisions go through one comparator instance, so area stays at one comparator regardless of DEPTH.

## Interface
Parameters:
- WIDTH, 8, element width in bits (unsigned).
- DEPTH, 8, elements per block; power of two, 2..16.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  element to load.
- in_valid  input  1  producer has an element.
- in_ready  output  1  high only in LOAD.
- out_data  output  WIDTH  sorted element, valid when out_valid.
- out_valid  output  1  high only in DRAIN.
- out_ready  input  1  consumer accepts.
- out_last  output  1  high with the final (DEPTH-th) output element.
- busy  output  1  high in SORT.

## Operation
- FSM states: LOAD -> SORT -> DRAIN -> LOAD.
- LOAD:
  - Transfer on in_valid & in_ready; byte written to buf[wr_idx], wr_idx increments.
  - On the transfer with wr_idx == DEPTH-1, next state is SORT; pass = 0, j = 0, swapped = 0.
- SORT, one compare per cycle:
  - Compare buf[j] vs buf[j+1] through the comparator.
  - If buf[j] > buf[j+1], swap the two and set swapped. Equal values are not swapped (stable).
  - If j < DEPTH-2-pass, then j++.
  - Otherwise the pass ends:
    - If no swap occurred in this pass (including this cycle), or pass == DEPTH-2, go to DRAIN with rd_idx = 0.
    - Otherwise pass++, j = 0, swapped = 0.
- DRAIN:
  - out_data = buf[rd_idx].
  - On out_valid & out_ready, rd_idx++.
  - On the transfer with rd_idx == DEPTH-1 (out_last high), go to LOAD with wr_idx = 0.
- All values compare as unsigned WIDTH-bit. Indices are $clog2(DEPTH) bits and never wrap inside a phase.
- Inputs outside their phase are ignored: in_valid outside LOAD and out_ready outside DRAIN.
- rst at any time, including mid-SORT or mid-DRAIN, aborts the block. Next cycle: state LOAD, indices 0, partial data discarded. buf contents are don't-care.

## Timing
- Reset values:
  - state = LOAD, so in_ready = 1.
  - out_valid = 0, out_last = 0, busy = 0.
  - wr_idx = rd_idx = j = pass = 0, swapped = 0.
  - out_data is don't-care.
- in_ready, out_valid, out_last and busy are decoded from registered state and indices. There is no combinational path from in_valid or out_ready to any output.
- SORT occupies the cycle after the last LOAD transfer.
- SORT length:
  - Already-sorted input: exactly DEPTH-1 cycles.
  - Worst case (strictly descending input): DEPTH*(DEPTH-1)/2 cycles, which is 28 for DEPTH=8.
- The first out_valid is the cycle after the last SORT cycle.
- DRAIN at full rate: DEPTH cycles. Backpressure holds out_data stable.
- in_ready rises the cycle after the out_last transfer. No overlap between blocks.

## Structure
- Shared package sort_pkg holds:
  - FSM state encodings (LOAD, SORT, DRAIN; 2 bits).
  - Default WIDTH/DEPTH constants.
- Sub-module cmp_swap (combinational):
  - Inputs: a, b.
  - Outputs: lo, hi, swap = (a > b).
  - Instantiated exactly once. The controller muxes buf[j]/buf[j+1] into it and writes lo/hi back.
- The buffer is a DEPTH x WIDTH register array, not RAM, because SORT needs two reads and two writes per cycle.

## Test plan
- Reset, then load 3,1,4,1,5,9,2,6 -> output 1,1,2,3,4,5,6,9. out_last is high only with 9.
- Load 0..7 ascending -> busy high exactly 7 cycles; output unchanged 0..7.
- Load 255,254,...,248 -> busy high exactly 28 cycles; output 248..255.
- Toggle out_ready randomly during DRAIN of all-0xAA input -> 8 transfers of 0xAA. out_data and out_valid stay stable while stalled.
- Assert rst mid-SORT after loading 8 bytes -> next cycle in_ready = 1 and busy = 0. Then load 7,6,5,4,3,2,1,0 -> output 0..7.
- Hold in_valid high with data during SORT and DRAIN -> extra bytes are not accepted and the output is uncorrupted.
